// File: rtl/seg_display.sv
// seg_display: 8-digit multiplexed hex display with a debounced go button.
// Define SEG_LEAD_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        halted,
  input  logic        go_btn,
  output logic        go,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PRESSED = 1'b1;
  logic [31:0]   display;
  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic          s1, s2, flip, wrap;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    nib;
  logic [6:0]    hex, seg7;
  assign wrap = pre == PW'(REFRESH_DIV - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      display <= '0;
      pre <= '0;
      idx <= '0;
    end else begin
      if (wr_en) display <= wr_data;
      pre <= wrap ? '0 : pre + PW'(1);
      if (wrap) idx <= idx + 3'd1;
    end
  end
  // Debounced level doubles as the FSM state; go fires only on the IDLE->PRESSED flip.
  assign flip = (s2 != state[0]) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      go <= 1'b0;
    end else begin
      s1 <= go_btn;
      s2 <= s1;
      cnt <= (s2 == state[0] || flip) ? '0 : cnt + CW'(1);
      if (flip) state <= (state == IDLE) ? PRESSED : IDLE;
      go <= flip && state == IDLE && halted;
    end
  end
  assign nib = display[{idx, 2'b00} +: 4];
  always_comb begin
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end
`ifdef SEG_LEAD_ZERO_BLANK_EN
  logic [2:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < 8; i++) if (display[4*i +: 4] != 4'h0) msd = 3'(i);
  end
  assign seg7 = (idx > msd) ? 7'h7F : hex;
`else
  assign seg7 = hex;
`endif
  assign an = ~(8'b1 << idx);
  assign seg = {~(halted && idx == 3'd0), seg7};
endmodule
